// File: rtl/bullet_pkg.sv
// Shared constants and slot record for the bullet sprite read path.
package bullet_pkg;
    localparam int SPR_W      = 7;
    localparam int SPR_H      = 25;
    localparam int SPR_WORDS  = SPR_W * SPR_H;
    localparam int TRANSP_IDX = 0;
    localparam int RAM_ADDR_W = 19;
    localparam int COORD_W    = 10;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } bullet_slot_t;
endpackage

// File: rtl/bullet_sprite_reader_if.sv
// Slot update port: valid/ready handshake carrying one bullet position.
interface bullet_sprite_reader_if
    import bullet_pkg::*;
#(
    parameter int COORD_W = bullet_pkg::COORD_W
);
    logic               upd_valid;
    logic               upd_ready;
    logic [2:0]         upd_slot;
    logic [COORD_W-1:0] upd_x;
    logic [COORD_W-1:0] upd_y;
    logic               upd_active;

    modport master (
        output upd_valid, upd_slot, upd_x, upd_y, upd_active,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_slot, upd_x, upd_y, upd_active,
        output upd_ready
    );
endinterface

// File: rtl/bullet_hit_test.sv
// Combinational box test of one pixel against one bullet slot.
module bullet_hit_test
    import bullet_pkg::*;
#(
    parameter int COORD_W = bullet_pkg::COORD_W,
    parameter int SPR_W   = bullet_pkg::SPR_W,
    parameter int SPR_H   = bullet_pkg::SPR_H
) (
    input  logic                  active,
    input  logic [COORD_W-1:0]    bx,
    input  logic [COORD_W-1:0]    by,
    input  logic [COORD_W-1:0]    draw_x,
    input  logic [COORD_W-1:0]    draw_y,
    output logic                  hit,
    output logic [RAM_ADDR_W-1:0] offset
);
    logic [COORD_W:0] bx_e, by_e, x_e, y_e, dx, dy;
    logic             in_x, in_y;

    // One extra bit so boxes hanging off the right/bottom edge never wrap.
    always_comb begin
        bx_e   = {1'b0, bx};
        by_e   = {1'b0, by};
        x_e    = {1'b0, draw_x};
        y_e    = {1'b0, draw_y};
        in_x   = (x_e >= bx_e) && (x_e < bx_e + (COORD_W+1)'(SPR_W));
        in_y   = (y_e >= by_e) && (y_e < by_e + (COORD_W+1)'(SPR_H));
        hit    = active && in_x && in_y;
        dx     = x_e - bx_e;
        dy     = y_e - by_e;
        offset = RAM_ADDR_W'(dy) * RAM_ADDR_W'(SPR_W) + RAM_ADDR_W'(dx);
    end
endmodule

// File: rtl/bullet_sprite_reader.sv
// Bullet sprite frame-RAM read side: slot table, per-pixel box test and
// re-alignment of pixel metadata with the registered RAM data.
module bullet_sprite_reader
    import bullet_pkg::*;
#(
    parameter int N_BULLETS  = 4,
    parameter int SPR_W      = bullet_pkg::SPR_W,
    parameter int SPR_H      = bullet_pkg::SPR_H,
    parameter int COORD_W    = bullet_pkg::COORD_W,
    parameter int TRANSP_IDX = bullet_pkg::TRANSP_IDX
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    bullet_sprite_reader_if.slave  upd,
    input  logic                   clear_all,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     DrawX,
    input  logic [COORD_W-1:0]     DrawY,
    output logic [RAM_ADDR_W-1:0]  read_address,
    input  logic [4:0]             ram_data,
    output logic                   out_valid,
    output logic                   out_hit,
    output logic [2:0]             out_idx,
    output logic [2:0]             out_slot
);
    localparam int TBL_CW = bullet_pkg::COORD_W;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    bullet_slot_t          slots_q [N_BULLETS];
    bullet_slot_t          slots_d [N_BULLETS];
    logic [0:0]            state_q, state_d;
    logic [2:0]            clr_cnt_q, clr_cnt_d;
    logic [RAM_ADDR_W-1:0] read_address_q, read_address_d;
    logic                  s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
    logic [2:0]            s1_slot_q, s1_slot_d;
    logic                  s2_valid_q, s2_valid_d, s2_hit_q, s2_hit_d;
    logic [2:0]            s2_slot_q, s2_slot_d;
    logic                  out_valid_q, out_valid_d, out_hit_q, out_hit_d;
    logic [2:0]            out_idx_q, out_idx_d, out_slot_q, out_slot_d;

    logic [N_BULLETS-1:0]  hit;
    logic [RAM_ADDR_W-1:0] offset [N_BULLETS];
    logic                  any_hit;
    logic [2:0]            sel_slot;
    logic [RAM_ADDR_W-1:0] sel_addr;
    logic                  ram_unused;

    assign ram_unused = ^ram_data[4:3];

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_hit
        bullet_hit_test #(
            .COORD_W (COORD_W),
            .SPR_W   (SPR_W),
            .SPR_H   (SPR_H)
        ) u_hit (
            .active (slots_q[g].active),
            .bx     (COORD_W'(slots_q[g].x)),
            .by     (COORD_W'(slots_q[g].y)),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit[g]),
            .offset (offset[g])
        );
    end

    // Walk from the top slot down so the lowest hitting index is left selected.
    always_comb begin
        any_hit  = 1'b0;
        sel_slot = '0;
        sel_addr = '0;
        for (int unsigned k = N_BULLETS; k > 0; k--) begin
            if (hit[k-1]) begin
                any_hit  = 1'b1;
                sel_slot = 3'(k - 1);
                sel_addr = offset[k-1];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        slots_d   = slots_q;
        case (state_q)
            ST_IDLE: begin
                if (upd.upd_valid) begin
                    for (int unsigned k = 0; k < N_BULLETS; k++) begin
                        if (upd.upd_slot == 3'(k)) begin
                            slots_d[k].active = upd.upd_active;
                            slots_d[k].x      = TBL_CW'(upd.upd_x);
                            slots_d[k].y      = TBL_CW'(upd.upd_y);
                        end
                    end
                end
                if (clear_all) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                for (int unsigned k = 0; k < N_BULLETS; k++) begin
                    if (clr_cnt_q == 3'(k)) slots_d[k].active = 1'b0;
                end
                if (clr_cnt_q == 3'(N_BULLETS - 1)) state_d = ST_IDLE;
                else clr_cnt_d = clr_cnt_q + 3'd1;
            end
        endcase

        s1_valid_d     = pix_valid;
        s1_hit_d       = pix_valid && any_hit;
        s1_slot_d      = sel_slot;
        read_address_d = (pix_valid && any_hit) ? sel_addr : read_address_q;
        s2_valid_d     = s1_valid_q;
        s2_hit_d       = s1_hit_q;
        s2_slot_d      = s1_slot_q;
        out_valid_d    = s2_valid_q;
        out_hit_d      = s2_hit_q && (ram_data[2:0] != 3'(TRANSP_IDX));
        out_idx_d      = out_hit_d ? ram_data[2:0] : '0;
        out_slot_d     = s2_slot_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned k = 0; k < N_BULLETS; k++) slots_q[k] <= '0;
            state_q        <= ST_IDLE;
            clr_cnt_q      <= '0;
            read_address_q <= '0;
            s1_valid_q     <= 1'b0;
            s1_hit_q       <= 1'b0;
            s1_slot_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_hit_q       <= 1'b0;
            s2_slot_q      <= '0;
            out_valid_q    <= 1'b0;
            out_hit_q      <= 1'b0;
            out_idx_q      <= '0;
            out_slot_q     <= '0;
        end else begin
            slots_q        <= slots_d;
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            read_address_q <= read_address_d;
            s1_valid_q     <= s1_valid_d;
            s1_hit_q       <= s1_hit_d;
            s1_slot_q      <= s1_slot_d;
            s2_valid_q     <= s2_valid_d;
            s2_hit_q       <= s2_hit_d;
            s2_slot_q      <= s2_slot_d;
            out_valid_q    <= out_valid_d;
            out_hit_q      <= out_hit_d;
            out_idx_q      <= out_idx_d;
            out_slot_q     <= out_slot_d;
        end
    end

    assign upd.upd_ready = (state_q == ST_IDLE);
    assign read_address  = read_address_q;
    assign out_valid     = out_valid_q;
    assign out_hit       = out_hit_q;
    assign out_idx       = out_idx_q;
    assign out_slot      = out_slot_q;
endmodule

// File: doc/bullet_sprite_reader.md
Name: bullet_sprite_reader

Overview:
- Read side of the bullet sprite frame RAM. Holds a table of up to N on-screen bullet positions, loaded through a valid/ready update port.
- For each incoming pixel coordinate from the VGA path, tests the pixel against every active bullet box and drives the frame RAM read address.
- Re-aligns the registered RAM data with its pixel metadata and emits a palette index with a transparency flag to the colour mapper.

Parameters:
- N_BULLETS, 4, number of bullet slots (1..8)
- SPR_W, 7, sprite width in pixels
- SPR_H, 25, sprite height in pixels (SPR_W*SPR_H = 175 RAM words)
- COORD_W, 10, width of screen coordinates
- TRANSP_IDX, 0, palette index treated as transparent

Ports:
- Clk  in  1  system clock, all state on posedge
- Reset_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  slot update request
- upd_ready  out  1  update accepted when high with upd_valid
- upd_slot  in  3  slot index (values >= N_BULLETS ignored, still handshaken)
- upd_x, upd_y  in  COORD_W each  top-left corner of bullet
- upd_active  in  1  slot enable
- clear_all  in  1  one-cycle pulse: deactivate every slot
- pix_valid  in  1  DrawX/DrawY qualify
- DrawX, DrawY  in  COORD_W each  current pixel
- read_address  out  19  to frame RAM read port
- ram_data  in  5  frame RAM data_Out (low 3 bits meaningful)
- out_valid  out  1  output pixel qualifier
- out_hit  out  1  opaque bullet pixel present
- out_idx  out  3  palette index (0 when out_hit=0)
- out_slot  out  3  winning slot

Behaviour:
- Reset (async, Reset_n=0): all slots inactive, x/y=0; state=IDLE; upd_ready=1; read_address=0; out_valid=0, out_hit=0, out_idx=0, out_slot=0; pipeline valids cleared. Reset mid-frame drops in-flight pixels.
- FSM IDLE / CLEAR:
  - IDLE: upd_ready=1; on upd_valid, write the slot at that edge.
  - clear_all in IDLE -> CLEAR. CLEAR deactivates slot c, one per cycle, c=0..N_BULLETS-1; upd_ready=0; then back to IDLE. A clear_all pulse during CLEAR is ignored.
  - clear_all and upd_valid in the same IDLE cycle: the update is accepted, then the clear wipes it.
- Hit test (stage 0, combinational on inputs, registered at edge t):
  - Slot k hits when active, bx <= DrawX < bx+SPR_W and by <= DrawY < by+SPR_H.
  - Compare in COORD_W+1 bits; boxes extending past the screen edge are not wrapped.
  - Lowest hitting index wins.
  - Address = (DrawY-by)*SPR_W + (DrawX-bx), zero-extended to 19 bits, range 0..174.
  - No hit: read_address holds its previous value.
  - The table is read before the same-edge update, so an update affects pixels sampled from the next edge.
- Pipeline:
  - Edge t: read_address, s1_valid, s1_hit and s1_slot are registered.
  - Edge t+1: RAM registers ram_data; metadata moves to s2.
  - Edge t+2: out_* registered, giving 2-cycle latency and one pixel per cycle throughput with no stalls.
  - out_hit = s2_hit AND ram_data[2:0] != TRANSP_IDX.
  - out_idx = ram_data[2:0] when out_hit, else 0.
  - pix_valid=0 propagates as out_valid=0 with out_hit=0.

Decomposition:
- Shared package bullet_pkg:
  - constants SPR_W, SPR_H, SPR_WORDS=175, TRANSP_IDX, RAM_ADDR_W=19
  - typedef bullet_slot_t {active, x, y}
- One sub-module, bullet_hit_test: combinational box test for one slot (hit, local offset). Instantiated N_BULLETS times; priority select and pipeline stay in the top.

Test Plan:
- Reset: hold Reset_n=0 mid-stream -> all out_* 0 and upd_ready=1 asynchronously. Release; first out_valid appears exactly 2 cycles after the first pix_valid.
- Single bullet: slot 0 at (100,50), RAM preloaded mem[a]=a%8.
  - Pixel (103,52) -> read_address=17; two cycles later out_hit=1, out_idx=1, out_slot=0.
  - Pixel (107,52) -> out_hit=0, out_valid=1.
- Transparency: pixel (100,50) with mem[0]=0 -> out_hit=0, out_idx=0.
- Priority/overlap: slot 2 at (10,10), slot 1 at (12,10); pixel (13,11) -> out_slot=1, read_address=8.
- Clear: set 4 slots, pulse clear_all -> upd_ready=0 for 4 cycles. An update offered during CLEAR is accepted only after upd_ready returns high; slots cleared before that are inactive (no hits).
- Boundary: slot at (636,470) with pixels x=639/y=479 -> hits with correct addresses; pixel x=0 -> no hit (no wrap). An update on the same edge as a pixel changes only later pixels.
